// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction ROM with byte-serial program loader
module inst_rom_loader #(
    parameter int          DEPTH        = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] DEFAULT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en,
    input  logic [31:0] addr,
    output logic [31:0] data,
    output logic        rd_valid,
    output logic        addr_err,
    input  logic        ld_start,
    input  logic [15:0] ld_count,
    input  logic [7:0]  ld_byte,
    input  logic        ld_byte_valid,
    output logic        busy,
    output logic        ld_done
);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_CNT = 17'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Program store; starts out holding DEFAULT_WORD and is never cleared by reset.
    logic [31:0] mem [DEPTH] = '{default: DEFAULT_WORD};

    logic [31:0] offset;
    logic [29:0] index;
    logic        in_range;
    logic        rd_ok;
    logic [16:0] ld_eff;
    logic [16:0] ptr;
    logic [16:0] eff_count;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic        word_done;

    // Address decode: offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    always_comb begin
        offset   = addr - BASE_ADDR;
        index    = offset[31:2];
        in_range = (offset[1:0] == 2'b00) && ({2'b00, index} < 32'(DEPTH));
        rd_ok    = rd_en && (state == IDLE);
        ld_eff   = ({1'b0, ld_count} > DEPTH_CNT) ? DEPTH_CNT : {1'b0, ld_count};
    end

    // Next-state logic; word_done marks the edge that commits an assembled word.
    always_comb begin
        state_next = state;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_next = (ld_count == 16'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (ld_byte_valid && (byte_cnt == 2'd3)) begin
                    word_done = 1'b1;
                    if (ptr + 17'd1 == eff_count) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state.
    always_comb begin
        busy    = (state != IDLE);
        ld_done = (state == DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read port: one-cycle latency, faulted reads return DEFAULT_WORD with addr_err set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data     <= 32'd0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            addr_err <= rd_ok && !in_range;
            if (rd_ok) begin
                data <= in_range ? mem[index[AW-1:0]] : DEFAULT_WORD;
            end
        end
    end

    // Loader bookkeeping: word pointer, byte lane counter and partial little-endian word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= 17'd0;
            eff_count <= 17'd0;
            byte_cnt  <= 2'd0;
            word_buf  <= 24'd0;
        end else if ((state == IDLE) && ld_start) begin
            ptr       <= 17'd0;
            eff_count <= ld_eff;
            byte_cnt  <= 2'd0;
        end else if ((state == LOAD) && ld_byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    word_buf[7:0]   <= ld_byte;
                2'd1:    word_buf[15:8]  <= ld_byte;
                2'd2:    word_buf[23:16] <= ld_byte;
                default: ptr             <= ptr + 17'd1;
            endcase
        end
    end

    // Memory write: the fourth byte goes straight into the top lane as the word is committed.
    always_ff @(posedge clk) begin
        if (word_done) begin
            mem[ptr[AW-1:0]] <= {ld_byte, word_buf};
        end
    end
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - directed self-checking bench for inst_rom_loader
module tb_inst_rom_loader;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] DEFW  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data;
    logic        rd_valid;
    logic        addr_err;
    logic        ld_start = 1'b0;
    logic [15:0] ld_count = 16'd0;
    logic [7:0]  ld_byte = 8'd0;
    logic        ld_byte_valid = 1'b0;
    logic        busy;
    logic        ld_done;

    int total = 0;
    int bad   = 0;

    logic        v;
    logic [31:0] d;
    logic        e;

    inst_rom_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .DEFAULT_WORD(DEFW)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .addr(addr), .data(data),
        .rd_valid(rd_valid), .addr_err(addr_err), .ld_start(ld_start),
        .ld_count(ld_count), .ld_byte(ld_byte), .ld_byte_valid(ld_byte_valid),
        .busy(busy), .ld_done(ld_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        ld_byte = b; ld_byte_valid = 1'b1;
        @(negedge clk);
        ld_byte_valid = 1'b0;
    endtask

    task automatic start_load(input logic [15:0] n);
        ld_start = 1'b1; ld_count = n;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] a, output logic ov, output logic [31:0] od, output logic oe);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        ov = rd_valid; od = data; oe = addr_err;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (data !== 32'd0) begin bad++; $display("FAIL rst_data got=%h want=00000000", data); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b want=0", rd_valid); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL rst_addr_err got=%b want=0", addr_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (ld_done !== 1'b0) begin bad++; $display("FAIL rst_ld_done got=%b want=0", ld_done); end
        reset = 1'b1;
        @(negedge clk);
        read_word(BASE + 32'd8, v, d, e);
        total++; if (v !== 1'b1 || d !== DEFW || e !== 1'b0) begin bad++; $display("FAIL init_word2 got v=%b d=%h e=%b want v=1 d=%h e=0", v, d, e, DEFW); end
    endtask

    task automatic test_load;
        start_load(16'd2);
        send_byte(8'h00); send_byte(8'h40); send_byte(8'h08); send_byte(8'h3c);
        send_byte(8'h0c); send_byte(8'h00); send_byte(8'h08);
        total++; if (ld_done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL load_mid got done=%b busy=%b want done=0 busy=1", ld_done, busy); end
        send_byte(8'h25);
        total++; if (ld_done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL load_done got done=%b busy=%b want done=1 busy=1", ld_done, busy); end
        @(negedge clk);
        total++; if (ld_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL load_idle got done=%b busy=%b want done=0 busy=0", ld_done, busy); end
        // back-to-back reads of words 0 and 1
        rd_en = 1'b1; addr = BASE;
        @(negedge clk);
        total++; if (rd_valid !== 1'b1 || data !== 32'h3c084000 || addr_err !== 1'b0) begin bad++; $display("FAIL load_rd0 got v=%b d=%h e=%b want v=1 d=3c084000 e=0", rd_valid, data, addr_err); end
        addr = BASE + 32'd4;
        @(negedge clk);
        total++; if (rd_valid !== 1'b1 || data !== 32'h2508000c || addr_err !== 1'b0) begin bad++; $display("FAIL load_rd1 got v=%b d=%h e=%b want v=1 d=2508000c e=0", rd_valid, data, addr_err); end
        rd_en = 1'b0;
        @(negedge clk);
        total++; if (rd_valid !== 1'b0 || addr_err !== 1'b0 || data !== 32'h2508000c) begin bad++; $display("FAIL load_hold got v=%b e=%b d=%h want v=0 e=0 d=2508000c", rd_valid, addr_err, data); end
    endtask

    task automatic test_faults;
        read_word(BASE + 32'd2, v, d, e);
        total++; if (v !== 1'b1 || d !== DEFW || e !== 1'b1) begin bad++; $display("FAIL fault_misalign got v=%b d=%h e=%b want v=1 d=%h e=1", v, d, e, DEFW); end
        read_word(BASE + 32'd4 * DEPTH, v, d, e);
        total++; if (v !== 1'b1 || d !== DEFW || e !== 1'b1) begin bad++; $display("FAIL fault_top got v=%b d=%h e=%b want v=1 d=%h e=1", v, d, e, DEFW); end
        read_word(BASE - 32'd4, v, d, e);
        total++; if (v !== 1'b1 || d !== DEFW || e !== 1'b1) begin bad++; $display("FAIL fault_below got v=%b d=%h e=%b want v=1 d=%h e=1", v, d, e, DEFW); end
        read_word(BASE + 32'd4 * (DEPTH - 1), v, d, e);
        total++; if (v !== 1'b1 || d !== DEFW || e !== 1'b0) begin bad++; $display("FAIL last_word got v=%b d=%h e=%b want v=1 d=%h e=0", v, d, e, DEFW); end
        @(negedge clk);
        total++; if (rd_valid !== 1'b0 || addr_err !== 1'b0) begin bad++; $display("FAIL fault_clear got v=%b e=%b want v=0 e=0", rd_valid, addr_err); end
    endtask

    task automatic test_busy_gating;
        start_load(16'd1);
        rd_en = 1'b1; addr = BASE;
        send_byte(8'h11);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL gate_b1 got v=%b want v=0", rd_valid); end
        send_byte(8'h22);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL gate_b2 got v=%b want v=0", rd_valid); end
        send_byte(8'h33);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL gate_b3 got v=%b want v=0", rd_valid); end
        send_byte(8'h44);
        total++; if (rd_valid !== 1'b0 || ld_done !== 1'b1) begin bad++; $display("FAIL gate_done got v=%b done=%b want v=0 done=1", rd_valid, ld_done); end
        @(negedge clk);
        total++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL gate_idle got v=%b busy=%b want v=0 busy=0", rd_valid, busy); end
        @(negedge clk);
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1 || data !== 32'h44332211) begin bad++; $display("FAIL gate_resume got v=%b d=%h want v=1 d=44332211", rd_valid, data); end
    endtask

    task automatic test_truncation;
        logic [31:0] exp;
        int early_done = 0;
        start_load(16'(DEPTH + 5));
        for (int w = 0; w < DEPTH; w++) begin
            send_byte(8'(w));
            send_byte(8'h5A);
            send_byte(8'hC3);
            if (ld_done !== 1'b0) early_done++;
            send_byte(8'h80 | 8'(w));
            if (w < DEPTH - 1 && ld_done !== 1'b0) early_done++;
        end
        total++; if (early_done != 0) begin bad++; $display("FAIL trunc_early got early=%0d want early=0", early_done); end
        total++; if (ld_done !== 1'b1) begin bad++; $display("FAIL trunc_done got done=%b want done=1", ld_done); end
        send_byte(8'hEE);
        total++; if (busy !== 1'b0 || ld_done !== 1'b0) begin bad++; $display("FAIL trunc_idle got busy=%b done=%b want busy=0 done=0", busy, ld_done); end
        for (int w = 0; w < DEPTH; w++) begin
            exp = {8'h80 | 8'(w), 8'hC3, 8'h5A, 8'(w)};
            read_word(BASE + 32'(4 * w), v, d, e);
            total++; if (v !== 1'b1 || d !== exp || e !== 1'b0) begin bad++; $display("FAIL trunc_word%0d got v=%b d=%h e=%b want v=1 d=%h e=0", w, v, d, e, exp); end
        end
    endtask

    task automatic test_zero_count;
        start_load(16'd0);
        total++; if (ld_done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL zero_done got done=%b busy=%b want done=1 busy=1", ld_done, busy); end
        send_byte(8'hFF);
        total++; if (ld_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_idle got done=%b busy=%b want done=0 busy=0", ld_done, busy); end
        send_byte(8'hFF);
        read_word(BASE, v, d, e);
        total++; if (d !== 32'h80C35A00) begin bad++; $display("FAIL zero_word0 got d=%h want d=80c35a00", d); end
        read_word(BASE + 32'd4, v, d, e);
        total++; if (d !== 32'h81C35A01) begin bad++; $display("FAIL zero_word1 got d=%h want d=81c35a01", d); end
    endtask

    task automatic test_reset_mid_load;
        start_load(16'd2);
        send_byte(8'h00); send_byte(8'h40); send_byte(8'h08);
        send_byte(8'h3c); send_byte(8'h0c); send_byte(8'h00);
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || ld_done !== 1'b0 || data !== 32'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst got busy=%b done=%b d=%h v=%b want busy=0 done=0 d=0 v=0", busy, ld_done, data, rd_valid); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        read_word(BASE, v, d, e);
        total++; if (v !== 1'b1 || d !== 32'h3c084000) begin bad++; $display("FAIL mid_word0 got v=%b d=%h want v=1 d=3c084000", v, d); end
        read_word(BASE + 32'd4, v, d, e);
        total++; if (v !== 1'b1 || d !== 32'h81C35A01) begin bad++; $display("FAIL mid_word1 got v=%b d=%h want v=1 d=81c35a01", v, d); end
        start_load(16'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        total++; if (ld_done !== 1'b1) begin bad++; $display("FAIL mid_reload_done got done=%b want done=1", ld_done); end
        @(negedge clk);
        read_word(BASE, v, d, e);
        total++; if (d !== 32'h04030201) begin bad++; $display("FAIL mid_reload got d=%h want d=04030201", d); end
    endtask

    task automatic test_simultaneous;
        rd_en = 1'b1; addr = BASE; ld_start = 1'b1; ld_count = 16'd1;
        @(negedge clk);
        rd_en = 1'b0; ld_start = 1'b0;
        total++; if (rd_valid !== 1'b1 || data !== 32'h04030201 || busy !== 1'b1) begin bad++; $display("FAIL simul got v=%b d=%h busy=%b want v=1 d=04030201 busy=1", rd_valid, data, busy); end
        send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc); send_byte(8'hdd);
        total++; if (ld_done !== 1'b1) begin bad++; $display("FAIL simul_done got done=%b want done=1", ld_done); end
        @(negedge clk);
        read_word(BASE, v, d, e);
        total++; if (d !== 32'hddccbbaa || e !== 1'b0) begin bad++; $display("FAIL simul_new got d=%h e=%b want d=ddccbbaa e=0", d, e); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_faults();
        test_busy_gating();
        test_truncation();
        test_zero_count();
        test_reset_mid_load();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 SHALL provide parameter DEPTH, default 256, number of 32-bit instruction words stored.
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL provide parameter DEFAULT_WORD, default 32'h0000_0000, word returned on any faulted read.
REQ-004 SHALL provide port clk  input  1  single system clock; all state changes on rising edge.
REQ-005 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port rd_en  input  1  read request.
REQ-007 SHALL provide port addr  input  32  byte address of read.
REQ-008 SHALL provide port data  output  32  registered read data.
REQ-009 SHALL provide port rd_valid  output  1  data valid, one cycle per accepted read.
REQ-010 SHALL provide port addr_err  output  1  fault flag qualifying rd_valid.
REQ-011 SHALL provide port ld_start  input  1  begin program load.
REQ-012 SHALL provide port ld_count  input  16  number of words to load, sampled with ld_start.
REQ-013 SHALL provide port ld_byte  input  8  load data byte.
REQ-014 SHALL provide port ld_byte_valid  input  1  ld_byte strobe, one byte per asserted cycle.
REQ-015 SHALL provide port busy  output  1  high while in LOAD or DONE.
REQ-016 SHALL provide port ld_done  output  1  one-cycle load-complete pulse.

Function
REQ-017 SHALL store DEPTH x 32-bit words; word index = (addr - BASE_ADDR) >> 2, computed modulo 2^32.
REQ-018 SHALL accept a read when rd_en=1 and FSM in IDLE; rd_valid=1 exactly one cycle later, latency 1.
REQ-019 SHALL, on an accepted read with addr[1:0]=0 and index < DEPTH, drive data=mem[index], addr_err=0.
REQ-020 SHALL, on an accepted read with addr[1:0]!=0 or index >= DEPTH (including addr below BASE_ADDR), drive data=DEFAULT_WORD, addr_err=1.
REQ-021 SHALL drive rd_valid=0 and addr_err=0 in cycles with no accepted read; data holds its last value.
REQ-022 SHALL ignore rd_en while busy=1 (no rd_valid produced, no queuing).
REQ-023 SHALL implement FSM IDLE -> LOAD -> DONE -> IDLE.
REQ-024 SHALL, in IDLE with ld_start=1 and ld_count!=0, enter LOAD with word pointer=0, byte counter=0, effective count=min(ld_count, DEPTH).
REQ-025 SHALL, in IDLE with ld_start=1 and ld_count=0, go directly to DONE (no writes).
REQ-026 SHALL, in LOAD, assemble bytes little-endian: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-027 SHALL, on the 4th byte, write the assembled word to mem[pointer] at that edge, increment pointer, clear byte counter.
REQ-028 SHALL go LOAD -> DONE on the edge writing the last word (pointer+1 = effective count).
REQ-029 SHALL remain in DONE one cycle with ld_done=1, then return to IDLE.
REQ-030 SHALL ignore ld_start in LOAD/DONE and ld_byte_valid outside LOAD.
REQ-031 SHALL, when rd_en and ld_start are both accepted in the same IDLE cycle, service the read from pre-load contents and start the load.
REQ-032 SHALL keep words beyond the loaded count unchanged.

Reset
REQ-033 SHALL, on reset=0 (any time, asynchronously), force FSM=IDLE, data=0, rd_valid=0, addr_err=0, busy=0, ld_done=0, pointer=0, byte counter=0.
REQ-034 SHALL, on reset mid-load, discard the partial word and retain already-written words; memory is never cleared by reset.
REQ-035 SHALL initialise memory to DEFAULT_WORD at configuration/time zero.

Verification
REQ-036 SHALL verify load: ld_start, ld_count=2, bytes 00,40,08,3c,0c,00,08,25 -> ld_done one cycle after 8th byte; read 0x0 -> 3c084000, read 0x4 -> 2508000c, addr_err=0, one cycle latency.
REQ-037 SHALL verify faults: read 0x2 -> DEFAULT_WORD, addr_err=1; read BASE_ADDR+4*DEPTH -> DEFAULT_WORD, addr_err=1.
REQ-038 SHALL verify busy gating: rd_en held during LOAD -> rd_valid=0 throughout; resumes the cycle after returning to IDLE.
REQ-039 SHALL verify truncation and zero count: ld_count=DEPTH+5 -> exactly DEPTH writes then ld_done; ld_count=0 -> ld_done next cycle, memory unchanged.
REQ-040 SHALL verify reset mid-load: reset after 6 bytes of ld_count=2 -> word 0 holds loaded value, word 1 unchanged, busy=0, FSM IDLE.
REQ-041 SHALL verify simultaneous rd_en+ld_start at 0x0 -> rd_valid with old word 0, busy=1 next cycle.
